piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 9 +
 rtl/piso_bit_counter.sv | 22 ++
 rtl/piso_serializer.sv | 66 ++++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared constants and the state type for the parallel-in/serial-out serializer.
package piso_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter: synchronous clear to zero, saturating increment, terminal-count flag.
module piso_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     tc
);
  localparam int CW = $clog2(WIDTH);

  assign tc = (count == CW'(WIDTH - 1));

  // Saturates at WIDTH-1 so a non-power-of-two width never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            count <= '0;
    else if (clear)       count <= '0;
    else if (en && !tc)   count <= count + CW'(1);
  end
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, MSB first, with back-to-back word acceptance on the last bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && tc;
  assign accept   = load_valid && load_ready;

  // Counter returns to zero on accept and when a frame ends, so IDLE always sees zero.
  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (accept || last_bit),
    .en    (state == SHIFT),
    .count (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (tc && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready   = (state == IDLE) || last_bit;
    serial_valid = (state == SHIFT);
    data_out     = (state == SHIFT) && sreg[WIDTH-1];
    frame_start  = (state == SHIFT) && (cnt == '0);
    done         = last_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                sreg <= '0;
    else if (accept)          sreg <= data_in;
    else if (state == SHIFT)  sreg <= {sreg[WIDTH-2:0], 1'b0};
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: 8-bit instance with loopback receiver, plus a 4-bit instance.
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       load_ready, data_out, serial_valid, frame_start, done;

  logic       load_valid4 = 1'b0;
  logic [3:0] data_in4 = '0;
  logic       load_ready4, data_out4, serial_valid4, frame_start4, done4;

  logic [7:0] sipo;
  int n_chk = 0;
  int n_pass = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .data_out(data_out), .serial_valid(serial_valid),
    .frame_start(frame_start), .done(done)
  );

  piso_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .load_valid(load_valid4), .load_ready(load_ready4),
    .data_in(data_in4), .data_out(data_out4), .serial_valid(serial_valid4),
    .frame_start(frame_start4), .done(done4)
  );

  always #5 clk = ~clk;

  // Receiving serial-in shift register, clocked only on valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             sipo <= '0;
    else if (serial_valid) sipo <= {sipo[6:0], data_out};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_vld"},   32'(serial_valid), 32'd0);
    chk({tag, "_dout"},  32'(data_out),     32'd0);
    chk({tag, "_fs"},    32'(frame_start),  32'd0);
    chk({tag, "_done"},  32'(done),         32'd0);
    chk({tag, "_rdy"},   32'(load_ready),   32'd1);
  endtask

  task automatic send8(input logic [7:0] w);
    load_valid = 1'b1;
    data_in    = w;
    tick();
    load_valid = 1'b0;
  endtask

  // Checks one 8-bit frame starting with its MSB visible. At bit inj_k a new word is
  // offered and held; with inj_k < 0 load_valid is dropped on the last bit.
  task automatic check_frame(input logic [7:0] w, input string tag,
                             input int inj_k, input logic [7:0] inj_w);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_b%0d", tag, k),   32'(data_out),     32'(w[7-k]));
      chk($sformatf("%s_v%0d", tag, k),   32'(serial_valid), 32'd1);
      chk($sformatf("%s_fs%0d", tag, k),  32'(frame_start),  32'(k == 0));
      chk($sformatf("%s_dn%0d", tag, k),  32'(done),         32'(k == 7));
      chk($sformatf("%s_rdy%0d", tag, k), 32'(load_ready),   32'(k == 7));
      if (k == inj_k) begin
        load_valid = 1'b1;
        data_in    = inj_w;
      end
      if (k == 7 && inj_k < 0) load_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [3:0] pat4;

    // Reset is applied from time zero; outputs must already be quiescent.
    #2;
    check_idle("rst");
    tick();
    tick();
    reset = 1'b0;
    check_idle("rel");

    // Single word 8'hA5
    send8(8'hA5);
    check_frame(8'hA5, "a5", -1, 8'h00);
    check_idle("a5_end");

    // Loopback into the receiver
    send8(8'h3C);
    check_frame(8'h3C, "lb", -1, 8'h00);
    chk("loopback", 32'(sipo), 32'h3C);
    check_idle("lb_end");

    // Back-to-back FF then 00 with load_valid held high
    load_valid = 1'b1;
    data_in    = 8'hFF;
    tick();
    check_frame(8'hFF, "b2b0", 0, 8'h00);
    check_frame(8'h00, "b2b1", -1, 8'h00);
    check_idle("b2b_end");

    // 7E offered during bit 3 of 81 must wait for the last-bit cycle
    send8(8'h81);
    check_frame(8'h81, "busy", 2, 8'h7E);
    check_frame(8'h7E, "late", -1, 8'h00);
    check_idle("late_end");

    // Mid-frame asynchronous reset at bit 4 of F0
    send8(8'hF0);
    tick();
    tick();
    tick();
    chk("pre_rst_dout", 32'(data_out), 32'd1);
    chk("pre_rst_vld",  32'(serial_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_idle("arst");
    tick();
    tick();
    reset = 1'b0;
    check_idle("arst_rel");
    send8(8'h0F);
    check_frame(8'h0F, "post", -1, 8'h00);
    check_idle("post_end");
    tick();
    check_idle("post_end2");

    // 4-bit instance
    pat4        = 4'b1001;
    load_valid4 = 1'b1;
    data_in4    = pat4;
    tick();
    load_valid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w4_b%0d", k),   32'(data_out4),     32'(pat4[3-k]));
      chk($sformatf("w4_v%0d", k),   32'(serial_valid4), 32'd1);
      chk($sformatf("w4_fs%0d", k),  32'(frame_start4),  32'(k == 0));
      chk($sformatf("w4_dn%0d", k),  32'(done4),         32'(k == 3));
      chk($sformatf("w4_rdy%0d", k), 32'(load_ready4),   32'(k == 3));
      tick();
    end
    chk("w4_idle_vld", 32'(serial_valid4), 32'd0);
    chk("w4_idle_rdy", 32'(load_ready4),   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
